unary_iter: RTL and testbench

Downstream consumer of the thermometer-code stage: takes one thermometer-coded word per handshake and iterates over it, emitting one output token per leading '1' bit. Each token carries the bit index and an end-of-transaction (eot) flag on the last token. Sits between the integer-to-thermometer stage and any per-item consumer, for example a loop body or an accumulator. Typical use turns a count N into N indexed iterations.

---
 rtl/unary_iter.sv | 106 ++++++++++
 tb/tb_unary_iter.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/unary_iter.sv
// unary_iter: iterates over a thermometer-coded word, emitting one token per
// leading '1' bit (bit 0 upward). Each token is {eot, index}; eot marks the
// final token of the word. Bits after the first zero are ignored.
//
// Ports:
//   clk         clock, rising edge
//   rst         asynchronous active-low reset
//   din_valid   input word valid
//   din_ready   input word accepted when high with din_valid
//   din_data    thermometer word, bit 0 first
//   dout_valid  output token valid
//   dout_ready  downstream ready
//   dout_data   {eot, index}
module unary_iter #(
    parameter int unsigned DIN = 16,
    parameter int unsigned IW  = $clog2(DIN)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           din_valid,
    output logic           din_ready,
    input  logic [DIN-1:0] din_data,
    output logic           dout_valid,
    input  logic           dout_ready,
    output logic [IW:0]    dout_data
);

    typedef enum logic [0:0] {
        StIdle,
        StEmit
    } state_e;

    localparam logic [IW-1:0] IdxMax = IW'(DIN - 1);

    state_e         state_q, state_d;
    logic [DIN-1:0] shreg_q, shreg_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic           last;
    logic           ready_int;

    // shreg[0] is the current bit; the run ends when the next bit is zero
    // or the final position of the word has been reached.
    assign last = ~shreg_q[1] | (idx_q == IdxMax);

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        idx_d      = idx_q;
        ready_int  = 1'b0;
        dout_valid = 1'b0;
        dout_data  = '0;

        unique case (state_q)
            StIdle: begin
                ready_int = 1'b1;
                // A word with bit 0 clear is a zero count: consumed, no token.
                if (din_valid && din_data[0]) begin
                    state_d = StEmit;
                    shreg_d = din_data;
                    idx_d   = '0;
                end
            end
            StEmit: begin
                dout_valid = 1'b1;
                dout_data  = {last, idx_q};
                if (dout_ready) begin
                    if (!last) begin
                        shreg_d = shreg_q >> 1;
                        idx_d   = idx_q + IW'(1);
                    end else begin
                        // Last token leaves this cycle: accept the next word
                        // now so back-to-back words have no bubble.
                        ready_int = 1'b1;
                        if (din_valid && din_data[0]) begin
                            shreg_d = din_data;
                            idx_d   = '0;
                        end else begin
                            state_d = StIdle;
                            shreg_d = '0;
                            idx_d   = '0;
                        end
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Held low throughout reset regardless of state.
    assign din_ready = ready_int & rst;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            shreg_q <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            idx_q   <= idx_d;
        end
    end

endmodule

// File: tb/tb_unary_iter.sv
module tb_unary_iter;

    localparam int unsigned DIN = 16;
    localparam int unsigned IW  = 4;

    logic           clk;
    logic           rst;
    logic           din_valid;
    logic           din_ready;
    logic [DIN-1:0] din_data;
    logic           dout_valid;
    logic           dout_ready;
    logic [IW:0]    dout_data;

    int checks;
    int errors;

    unary_iter #(.DIN(DIN)) dut (
        .clk        (clk),
        .rst        (rst),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .din_data   (din_data),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .dout_data  (dout_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past the next rising edge; inputs change 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; din_valid = 1'b0; din_data = '0; dout_ready = 1'b0;
        #3;
        checks++;
        if (dout_valid !== 1'b0) begin
            errors++; $display("FAIL reset_dout_valid: got %b want 0", dout_valid);
        end
        checks++;
        if (din_ready !== 1'b0) begin
            errors++; $display("FAIL reset_din_ready: got %b want 0", din_ready);
        end
        checks++;
        if (dout_data !== 5'h00) begin
            errors++; $display("FAIL reset_dout_data: got %h want 00", dout_data);
        end
        tick(); tick();
        rst = 1'b1;
        #1;
        checks++;
        if (din_ready !== 1'b1) begin
            errors++; $display("FAIL reset_release_din_ready: got %b want 1", din_ready);
        end
    endtask

    task automatic test_basic();
        logic [IW:0] exp_d [3];
        logic        exp_r [3];
        exp_d[0] = 5'h00; exp_d[1] = 5'h01; exp_d[2] = 5'h12;
        exp_r[0] = 1'b0;  exp_r[1] = 1'b0;  exp_r[2] = 1'b1;
        tick();
        din_valid = 1'b1; din_data = 16'h0007; dout_ready = 1'b1;
        #1;
        checks++;
        if (din_ready !== 1'b1) begin
            errors++; $display("FAIL basic_idle_ready: got %b want 1", din_ready);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            din_valid = 1'b0;
            #1;
            checks++;
            if (dout_valid !== 1'b1 || dout_data !== exp_d[i]) begin
                errors++;
                $display("FAIL basic_token%0d: got v=%b d=%h want v=1 d=%h",
                         i, dout_valid, dout_data, exp_d[i]);
            end
            checks++;
            if (din_ready !== exp_r[i]) begin
                errors++;
                $display("FAIL basic_din_ready%0d: got %b want %b", i, din_ready, exp_r[i]);
            end
        end
        tick(); #1;
        checks++;
        if (dout_valid !== 1'b0) begin
            errors++; $display("FAIL basic_end_idle: got %b want 0", dout_valid);
        end
    endtask

    task automatic test_zero_count();
        din_valid = 1'b1; din_data = 16'h0000; dout_ready = 1'b1;
        tick();
        din_data = 16'h0001;
        #1;
        checks++;
        if (dout_valid !== 1'b0 || din_ready !== 1'b1) begin
            errors++;
            $display("FAIL zero_no_token: got v=%b r=%b want v=0 r=1", dout_valid, din_ready);
        end
        tick();
        din_valid = 1'b0;
        #1;
        checks++;
        if (dout_valid !== 1'b1 || dout_data !== 5'h10) begin
            errors++;
            $display("FAIL zero_single_token: got v=%b d=%h want v=1 d=10", dout_valid, dout_data);
        end
        tick(); #1;
        checks++;
        if (dout_valid !== 1'b0) begin
            errors++; $display("FAIL zero_end_idle: got %b want 0", dout_valid);
        end
    endtask

    task automatic test_all_ones();
        logic [IW:0] exp;
        int          bad;
        bad = 0;
        din_valid = 1'b1; din_data = 16'hFFFF; dout_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
            din_valid = 1'b0;
            #1;
            exp = {(i == 15), 4'(i)};
            checks++;
            if (dout_valid !== 1'b1 || dout_data !== exp) begin
                errors++;
                $display("FAIL ones_token%0d: got v=%b d=%h want v=1 d=%h",
                         i, dout_valid, dout_data, exp);
            end
        end
        tick(); #1;
        checks++;
        if (dout_valid !== 1'b0) begin
            errors++; $display("FAIL ones_end_idle: got %b want 0", dout_valid);
        end
    endtask

    task automatic test_bubble();
        din_valid = 1'b1; din_data = 16'h00F3; dout_ready = 1'b1;
        tick();
        din_valid = 1'b0;
        #1;
        checks++;
        if (dout_valid !== 1'b1 || dout_data !== 5'h00) begin
            errors++;
            $display("FAIL bubble_token0: got v=%b d=%h want v=1 d=00", dout_valid, dout_data);
        end
        tick(); #1;
        checks++;
        if (dout_valid !== 1'b1 || dout_data !== 5'h11) begin
            errors++;
            $display("FAIL bubble_token1: got v=%b d=%h want v=1 d=11", dout_valid, dout_data);
        end
        tick(); #1;
        checks++;
        if (dout_valid !== 1'b0) begin
            errors++; $display("FAIL bubble_end_idle: got %b want 0", dout_valid);
        end
    endtask

    task automatic test_stall();
        logic [IW:0] exp;
        int          k;
        int          c;
        k = 0;
        c = 0;
        din_valid = 1'b1; din_data = 16'h000F; dout_ready = 1'b0;
        tick();
        din_valid = 1'b0;
        while (k < 4 && c < 20) begin
            dout_ready = (c % 3 == 0);
            #1;
            exp = {(k == 3), 4'(k)};
            checks++;
            if (dout_valid !== 1'b1 || dout_data !== exp) begin
                errors++;
                $display("FAIL stall_cycle%0d: got v=%b d=%h want v=1 d=%h",
                         c, dout_valid, dout_data, exp);
            end
            if (dout_ready) k++;
            c++;
            tick();
        end
        dout_ready = 1'b0;
        #1;
        checks++;
        if (k != 4 || dout_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_count: got tokens=%0d v=%b want tokens=4 v=0", k, dout_valid);
        end
    endtask

    task automatic test_back_to_back();
        din_valid = 1'b1; din_data = 16'h0003; dout_ready = 1'b1;
        tick();
        din_data = 16'h0001;
        #1;
        checks++;
        if (dout_valid !== 1'b1 || dout_data !== 5'h00 || din_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_token0: got v=%b d=%h r=%b want v=1 d=00 r=0",
                     dout_valid, dout_data, din_ready);
        end
        tick(); #1;
        checks++;
        if (dout_valid !== 1'b1 || dout_data !== 5'h11 || din_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_token1: got v=%b d=%h r=%b want v=1 d=11 r=1",
                     dout_valid, dout_data, din_ready);
        end
        tick();
        din_valid = 1'b0;
        #1;
        checks++;
        if (dout_valid !== 1'b1 || dout_data !== 5'h10) begin
            errors++;
            $display("FAIL b2b_token2: got v=%b d=%h want v=1 d=10", dout_valid, dout_data);
        end
        tick(); #1;
        checks++;
        if (dout_valid !== 1'b0) begin
            errors++; $display("FAIL b2b_end_idle: got %b want 0", dout_valid);
        end
    endtask

    task automatic test_reset_abort();
        din_valid = 1'b1; din_data = 16'h00FF; dout_ready = 1'b1;
        tick();
        din_valid = 1'b0;
        tick(); #1;
        checks++;
        if (dout_valid !== 1'b1 || dout_data !== 5'h01) begin
            errors++;
            $display("FAIL abort_token1: got v=%b d=%h want v=1 d=01", dout_valid, dout_data);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (dout_valid !== 1'b0 || din_ready !== 1'b0 || dout_data !== 5'h00) begin
            errors++;
            $display("FAIL abort_async: got v=%b r=%b d=%h want v=0 r=0 d=00",
                     dout_valid, din_ready, dout_data);
        end
        tick();
        rst = 1'b1;
        din_valid = 1'b1; din_data = 16'h0001;
        #1;
        checks++;
        if (din_ready !== 1'b1 || dout_valid !== 1'b0) begin
            errors++;
            $display("FAIL abort_release: got r=%b v=%b want r=1 v=0", din_ready, dout_valid);
        end
        tick();
        din_valid = 1'b0;
        #1;
        checks++;
        if (dout_valid !== 1'b1 || dout_data !== 5'h10) begin
            errors++;
            $display("FAIL abort_fresh_token: got v=%b d=%h want v=1 d=10", dout_valid, dout_data);
        end
        tick(); #1;
        checks++;
        if (dout_valid !== 1'b0) begin
            errors++; $display("FAIL abort_no_stale: got %b want 0", dout_valid);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic();
        test_zero_count();
        test_all_ones();
        test_bubble();
        test_stall();
        test_back_to_back();
        test_reset_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
